riscv_fetch_aligner: RTL
========================

Name: riscv_fetch_aligner

Overview:
- Parametrised successor to the 32-bit prefetch front-end.
- Word-fetches from the instruction memory into a DEPTH-entry FIFO, with up to MAX_OUTSTANDING pipelined requests.
- Realigns 16/32-bit RVC-mixed instruction streams, including 32-bit instructions straddling a word boundary, so ID sees one complete instruction per handshake.
- Sits between the instruction memory/cache port and the IF/ID pipeline registers; the current front-end lacks this realignment.

Parameters:
- DEPTH, 4, FIFO entries (32-bit words); power of two, >=2.
- MAX_OUTSTANDING, 2, maximum granted-but-not-returned requests; 1..DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  fetch enable
- branch_i  in  1  redirect fetch (single-cycle pulse)
- branch_addr_i  in  32  redirect target; bit0 ignored
- ready_i  in  1  consumer accepts current instruction
- valid_o  out  1  rdata_o/addr_o hold a complete instruction
- rdata_o  out  32  instruction, unexpanded; compressed = {16'h0, halfword}
- addr_o  out  32  PC of rdata_o
- is_compressed_o  out  1  rdata_o[1:0] != 2'b11
- err_o  out  1  any word forming the instruction returned with error
- instr_req_o  out  1  memory request
- instr_addr_o  out  32  word-aligned request address
- instr_gnt_i  in  1  request grant
- instr_rvalid_i  in  1  response valid
- instr_rdata_i  in  32  response data
- instr_err_i  in  1  response error (PMP/bus), qualified by rvalid
- busy_o  out  1  outstanding != 0 or instr_req_o

Behaviour:
- Reset: valid_o=0, instr_req_o=0, busy_o=0, err_o=0, is_compressed_o=0, rdata_o/addr_o/instr_addr_o=0.
- FIFO and discard counter clear; offset=0; request FSM in IDLE.
- Request FSM states:
  - IDLE: go to REQ when req_i && (fifo_cnt + outstanding) < DEPTH && outstanding < MAX_OUTSTANDING.
  - REQ: instr_req_o=1; instr_req_o and instr_addr_o stay stable until gnt. On gnt: outstanding++, fetch_addr += 4, then stay in REQ if still eligible, else go to IDLE.
- A pending un-granted request is never withdrawn or altered, including across branch_i.
- A branch during REQ loads the new fetch address, which is used after the current gnt.
- rvalid: outstanding--. If discard_cnt>0, drop the data and decrement discard_cnt; else push {rdata, err}. Push can never overflow by construction.
- Branch (cycle of branch_i):
  - FIFO flushed; valid_o=0 same cycle.
  - discard_cnt <= outstanding, after same-cycle gnt/rvalid adjustments.
  - fetch_addr <= {addr[31:2],2'b00}; offset <= addr[1]; output PC <= {addr[31:1],1'b0}.
  - In IDLE, a request is issued the next cycle.
- Aligner (combinational from FIFO head w0 and next w1):
  - offset 0, w0 present: if w0[1:0]!=11, compressed = w0[15:0]; else 32-bit instruction = w0.
  - offset 1, w0 present, w0[17:16]!=11: compressed = w0[31:16].
  - offset 1, 32-bit: needs w1; instr = {w1[15:0], w0[31:16]}; valid_o=0 until w1 present.
  - err_o = OR of err flags of the words used. An erroneous w0 at offset 1 is presented immediately as a 32-bit instruction with err_o=1, without waiting for w1.
- Handshake: transfer on valid_o && ready_i.
  - addr_o += 2 (compressed) or += 4.
  - Pops: offset0+C: none, offset<=1. offset0+32: pop 1. offset1+C: pop 1, offset<=0. offset1+32: pop 1, offset stays 1.
  - valid_o, rdata_o, addr_o hold while !ready_i. Combinational output from the FIFO, zero added latency.
- Latency: branch on cycle N, gnt on N+1, rvalid on N+2 -> valid_o on N+2.
- Simultaneous events: branch_i overrides pop and push in the same cycle, and same-cycle rvalid data is discarded. Push and pop in the same cycle are legal when full.
- Address wrap: fetch_addr and addr_o wrap modulo 2^32.
- req_i=0 stops new requests only; outstanding responses are still accepted and buffered.
- Reset mid-operation: all state cleared asynchronously. Responses arriving after reset deassertion are not tracked; the memory side is reset together with this block.

Test Plan:
- Reset, req_i=1, branch to 0x100, zero-wait memory returning 0x00000013 -> requests 0x100, 0x104...; valid_o on rvalid cycle; addr_o 0x100, 0x104; is_compressed_o=0.
- Words 0x45014501 at 0x200 -> two compressed instructions rdata_o=0x00004501 at 0x200 and 0x202, single pop.
- Branch to 0x302, word0=0x00134501, word1=0x00000001 -> first 0x00004501 @0x302? No: offset1 half 0x0013 is 32-bit, so valid_o waits for w1; instr 0x00010013 @0x302, next @0x306 compressed 0x0000.
- ready_i=0 for 10 cycles with DEPTH=4, MAX_OUTSTANDING=2 -> at most 4 words buffered, instr_req_o drops; data held stable; resume gives in-order output.
- Branch while 2 requests outstanding and 1 un-granted -> un-granted request holds its address until gnt; 3 stale responses dropped; first valid_o carries the target address.
- instr_err_i=1 on word at 0x400 -> err_o=1 for the instruction at 0x400; instruction straddling 0x3FE/0x400 also err_o=1.

Source files
------------

// File: rtl/riscv_fetch_aligner.sv
// Instruction prefetch buffer with RVC realignment: word fetches feed a small FIFO, and the
// aligner presents one complete 16/32-bit instruction per handshake.
module riscv_fetch_aligner #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        is_compressed_o,
  output logic        err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [CntW-1:0] cnt_t;
  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     req_addr_q, req_addr_d;
  cnt_t            outst_q, outst_d;
  cnt_t            discard_q, discard_d;
  cnt_t            cnt_q, cnt_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic            offset_q, offset_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     mem_data_q [DEPTH];
  logic            mem_err_q  [DEPTH];

  logic            gnt_acc, pend, rsp_keep, push, pop, fire, eligible, issue;
  logic            have0, have1, e0, e1, instr_ok, comp, ierr, need_pop;
  logic [31:0]     w0, w1, instr, base;
  logic [15:0]     hi;
  logic [CntW:0]   occ;
  logic            unused_bits;

  assign unused_bits = ^{branch_addr_i[0], w1[31:16]};

  assign gnt_acc  = (state_q == StReq) && instr_gnt_i;
  assign pend     = (state_q == StReq) && !instr_gnt_i;
  assign rsp_keep = instr_rvalid_i && (discard_q == '0);
  assign push     = rsp_keep && !branch_i;

  // Window onto the two oldest words; a response arriving this cycle acts as the tail so
  // data reaches the aligner with no added latency.
  always_comb begin
    w0    = '0;
    e0    = 1'b0;
    have0 = 1'b0;
    w1    = '0;
    e1    = 1'b0;
    have1 = 1'b0;
    if (cnt_q == '0) begin
      have0 = rsp_keep;
      w0    = instr_rdata_i;
      e0    = instr_err_i;
    end else begin
      have0 = 1'b1;
      w0    = mem_data_q[rd_ptr_q];
      e0    = mem_err_q[rd_ptr_q];
      if (cnt_q == cnt_t'(1)) begin
        have1 = rsp_keep;
        w1    = instr_rdata_i;
        e1    = instr_err_i;
      end else begin
        have1 = 1'b1;
        w1    = mem_data_q[rd_ptr_q + PtrW'(1)];
        e1    = mem_err_q[rd_ptr_q + PtrW'(1)];
      end
    end
  end

  always_comb begin
    hi       = w0[31:16];
    instr_ok = 1'b0;
    instr    = '0;
    comp     = 1'b0;
    ierr     = 1'b0;
    need_pop = 1'b0;
    if (!offset_q) begin
      instr_ok = have0;
      ierr     = e0;
      if (w0[1:0] != 2'b11) begin
        comp  = 1'b1;
        instr = {16'h0, w0[15:0]};
      end else begin
        instr    = w0;
        need_pop = 1'b1;
      end
    end else if (hi[1:0] != 2'b11) begin
      instr_ok = have0;
      comp     = 1'b1;
      instr    = {16'h0, hi};
      ierr     = e0;
      need_pop = 1'b1;
    end else begin
      instr    = {w1[15:0], hi};
      need_pop = 1'b1;
      // A faulting first half is reported at once; its second word may never come.
      if (have0 && e0) begin
        instr_ok = 1'b1;
        ierr     = 1'b1;
      end else begin
        instr_ok = have0 && have1;
        ierr     = e0 | e1;
      end
    end
  end

  assign valid_o         = instr_ok && !branch_i;
  assign rdata_o         = valid_o ? instr : '0;
  assign is_compressed_o = valid_o && comp;
  assign err_o           = valid_o && ierr;
  assign addr_o          = pc_q;
  assign fire            = valid_o && ready_i;
  assign pop             = fire && need_pop;
  assign instr_req_o     = (state_q == StReq);
  assign instr_addr_o    = req_addr_q;
  assign busy_o          = (outst_q != '0) || instr_req_o;

  always_comb begin
    outst_d   = outst_q + cnt_t'(gnt_acc) - cnt_t'(instr_rvalid_i);
    discard_d = discard_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    pc_d      = pc_q;
    offset_d  = offset_q;
    if (instr_rvalid_i && (discard_q != '0)) discard_d = discard_q - cnt_t'(1);
    if (branch_i) begin
      // Everything in flight is stale, including a request still waiting for its grant.
      discard_d = outst_d + cnt_t'(pend);
      cnt_d     = '0;
      rd_ptr_d  = wr_ptr_q;
      pc_d      = {branch_addr_i[31:1], 1'b0};
      offset_d  = branch_addr_i[1];
    end else begin
      cnt_d    = cnt_q + cnt_t'(push) - cnt_t'(pop);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      if (fire) begin
        pc_d = pc_q + (comp ? 32'd2 : 32'd4);
        if (comp) offset_d = !offset_q;
      end
    end
  end

  always_comb begin
    base         = branch_i ? {branch_addr_i[31:2], 2'b00} : fetch_addr_q;
    occ          = {1'b0, cnt_d} + {1'b0, outst_d};
    eligible     = req_i && (occ < (CntW+1)'(DEPTH)) && (outst_d < CntW'(MAX_OUTSTANDING));
    issue        = ((state_q == StIdle) || gnt_acc) && eligible;
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    fetch_addr_d = base;
    if (issue) begin
      state_d      = StReq;
      req_addr_d   = base;
      fetch_addr_d = base + 32'd4;
    end else if ((state_q == StIdle) || gnt_acc) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fetch_addr_q <= '0;
      req_addr_q   <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      offset_q     <= 1'b0;
      pc_q         <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      offset_q     <= offset_d;
      pc_q         <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= instr_rdata_i;
      mem_err_q[wr_ptr_q]  <= instr_err_i;
    end
  end

endmodule
